// File: rtl/uart_pkg.sv
// Shared UART definitions: TX state encodings, default data width and divisor width.
// Used by uart_tx, uart_baud_gen, and also by uart_rx and the FIFO.
package uart_pkg;

  localparam int UART_DATA_BITS = 8;
  localparam int UART_DIV_W     = 16;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_FETCH  = 3'd1;
  localparam logic [2:0] ST_LOAD   = 3'd2;
  localparam logic [2:0] ST_START  = 3'd3;
  localparam logic [2:0] ST_DATA   = 3'd4;
  localparam logic [2:0] ST_PARITY = 3'd5;
  localparam logic [2:0] ST_STOP   = 3'd6;

  typedef enum logic [2:0] {
    S_IDLE   = ST_IDLE,
    S_FETCH  = ST_FETCH,
    S_LOAD   = ST_LOAD,
    S_START  = ST_START,
    S_DATA   = ST_DATA,
    S_PARITY = ST_PARITY,
    S_STOP   = ST_STOP
  } tx_state_e;

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period down-counter. A start strobe loads and latches the divisor, and
// bit_tick marks the last clk of each period.
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int DIV_W = UART_DIV_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [DIV_W-1:0] div,
  output logic             bit_tick,
  output logic             bit_tick_nxt
);

  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] cnt_d;
  logic [DIV_W-1:0] div_q;

  // bit_tick_nxt predicts the next cycle's tick, so the owner can register
  // outputs that must line up with the final clk of a bit.
  always_comb begin
    cnt_d = cnt;
    if (start)
      cnt_d = div;
    else if (cnt == '0)
      cnt_d = div_q;
    else
      cnt_d = cnt - 1'b1;
  end

  assign bit_tick     = (cnt == '0);
  assign bit_tick_nxt = (cnt_d == '0);

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      div_q <= '0;
    end else begin
      cnt <= cnt_d;
      if (start)
        div_q <= div;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter at the read side of the TX FIFO: pops one byte per frame and
// drives 8N1/8N2 on txd. Define UART_TX_PARITY_EN to add an optional parity bit.
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_BITS = UART_DATA_BITS,
  parameter int DIV_W     = UART_DIV_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tx_en,
  input  logic [DIV_W-1:0]     baud_div,
  input  logic                 stop2,
`ifdef UART_TX_PARITY_EN
  input  logic                 parity_en,
  input  logic                 parity_odd,
`endif
  input  logic                 fifo_rempty,
  input  logic [DATA_BITS-1:0] fifo_data,
  output logic                 fifo_rinc,
  output logic                 txd,
  output logic                 busy,
  output logic                 tx_done
);

  localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

  tx_state_e            state, state_d;
  logic [DATA_BITS-1:0] shreg, shreg_d;
  logic [IDX_W-1:0]     bit_idx, bit_idx_d;
  logic                 stop_cnt, stop_cnt_d;
  logic                 stop2_q, stop2_d;
  logic                 par, par_d;
  logic                 par_en_q, par_en_d;
  logic                 txd_d, rinc_d, busy_d, done_d;
  logic                 bit_tick, bit_tick_nxt;
  logic                 load_par_en, load_par_odd;

`ifdef UART_TX_PARITY_EN
  assign load_par_en  = parity_en;
  assign load_par_odd = parity_odd;
`else
  assign load_par_en  = 1'b0;
  assign load_par_odd = 1'b0;
`endif

  uart_baud_gen #(.DIV_W(DIV_W)) u_baud_gen (
    .clk          (clk),
    .rst          (rst),
    .start        (state == S_LOAD),
    .div          (baud_div),
    .bit_tick     (bit_tick),
    .bit_tick_nxt (bit_tick_nxt)
  );

  // NOTE: every variable gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d    = state;
    shreg_d    = shreg;
    bit_idx_d  = bit_idx;
    stop_cnt_d = stop_cnt;
    stop2_d    = stop2_q;
    par_d      = par;
    par_en_d   = par_en_q;

    case (state)
      S_IDLE:  if (tx_en && !fifo_rempty) state_d = S_FETCH;
      S_FETCH: state_d = S_LOAD;
      S_LOAD: begin
        state_d    = S_START;
        shreg_d    = fifo_data;
        bit_idx_d  = '0;
        stop_cnt_d = 1'b0;
        stop2_d    = stop2;
        par_d      = load_par_odd;
        par_en_d   = load_par_en;
      end
      S_START: if (bit_tick) state_d = S_DATA;
      S_DATA: if (bit_tick) begin
        par_d   = par ^ shreg[0];
        shreg_d = shreg >> 1;
        if (bit_idx == LAST_IDX)
          state_d = par_en_q ? S_PARITY : S_STOP;
        else
          bit_idx_d = bit_idx + 1'b1;
      end
      S_PARITY: if (bit_tick) state_d = S_STOP;
      S_STOP: if (bit_tick) begin
        if (stop2_q && !stop_cnt) begin
          stop_cnt_d = 1'b1;
        end else begin
          stop_cnt_d = 1'b0;
          state_d    = (tx_en && !fifo_rempty) ? S_FETCH : S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are decoded from the next state so they register alongside it.
    case (state_d)
      S_START:  txd_d = 1'b0;
      S_DATA:   txd_d = shreg_d[0];
      S_PARITY: txd_d = par_d;
      default:  txd_d = 1'b1;
    endcase
    rinc_d = (state_d == S_FETCH);
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_STOP) && bit_tick_nxt && (!stop2_d || stop_cnt_d);
  end

  // NOTE: the shift register is reset along with the control state; it is a
  // handful of flops, and a known value keeps txd clean after an abort.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      shreg     <= '0;
      bit_idx   <= '0;
      stop_cnt  <= 1'b0;
      stop2_q   <= 1'b0;
      par       <= 1'b0;
      par_en_q  <= 1'b0;
      txd       <= 1'b1;
      fifo_rinc <= 1'b0;
      busy      <= 1'b0;
      tx_done   <= 1'b0;
    end else begin
      state     <= state_d;
      shreg     <= shreg_d;
      bit_idx   <= bit_idx_d;
      stop_cnt  <= stop_cnt_d;
      stop2_q   <= stop2_d;
      par       <= par_d;
      par_en_q  <= par_en_d;
      txd       <= txd_d;
      fifo_rinc <= rinc_d;
      busy      <= busy_d;
      tx_done   <= done_d;
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed self-checking bench for uart_tx with a small registered-read FIFO model.
// Define UART_TX_PARITY_EN to also exercise the parity frames.
module tb_uart_tx;

  logic        clk = 1'b0;
  logic        rst;
  logic        tx_en;
  logic [15:0] baud_div;
  logic        stop2;
`ifdef UART_TX_PARITY_EN
  logic        parity_en;
  logic        parity_odd;
`endif
  logic        fifo_rempty;
  logic [7:0]  fifo_data = 8'h00;
  logic        fifo_rinc;
  logic        txd;
  logic        busy;
  logic        tx_done;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] mem [0:31];
  logic [4:0] wr_ptr = '0;
  logic [4:0] rd_ptr = '0;
  int pops      = 0;
  int bad_pops  = 0;
  int done_cnt  = 0;
  int exp_pops  = 0;
  int exp_done  = 0;

  always #5 clk = ~clk;

  uart_tx dut (
    .clk         (clk),
    .rst         (rst),
    .tx_en       (tx_en),
    .baud_div    (baud_div),
    .stop2       (stop2),
`ifdef UART_TX_PARITY_EN
    .parity_en   (parity_en),
    .parity_odd  (parity_odd),
`endif
    .fifo_rempty (fifo_rempty),
    .fifo_data   (fifo_data),
    .fifo_rinc   (fifo_rinc),
    .txd         (txd),
    .busy        (busy),
    .tx_done     (tx_done)
  );

  assign fifo_rempty = (wr_ptr == rd_ptr);

  // FIFO read side: data appears the cycle after the pop strobe.
  always @(posedge clk) begin
    if (fifo_rinc) begin
      pops <= pops + 1;
      if (fifo_rempty) begin
        bad_pops <= bad_pops + 1;
      end else begin
        fifo_data <= mem[rd_ptr];
        rd_ptr    <= rd_ptr + 5'd1;
      end
    end
    if (tx_done) done_cnt <= done_cnt + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] d);
    mem[wr_ptr] = d;
    wr_ptr = wr_ptr + 5'd1;
  endtask

  // Waits for the start bit; a fresh pop shows rinc one clk after the request and txd low three clks after.
  task automatic wait_start(input string tag);
    int n, rinc_first, rinc_cnt;
    n = 0; rinc_first = 0; rinc_cnt = 0;
    do begin
      @(negedge clk);
      n++;
      if (fifo_rinc === 1'b1) begin
        rinc_cnt++;
        if (rinc_first == 0) rinc_first = n;
      end
    end while (txd !== 1'b0 && n < 50);
    check({tag, "_latency"}, n, 3);
    check({tag, "_rinc_at"}, rinc_first, 1);
    check({tag, "_rinc_cnt"}, rinc_cnt, 1);
  endtask

  // Called on the first START cycle; checks every clk of the frame.
  task automatic check_frame(input string tag, input logic [7:0] data, input int div,
                             input int nstop, input int par);
    logic [11:0] bits;
    int nbits, total, bad_txd, bad_done, bad_busy;
    bits = '1;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[1 + i] = data[i];
    nbits = 9;
    if (par >= 0) begin
      bits[nbits] = par[0];
      nbits++;
    end
    nbits += nstop;
    total = nbits * (div + 1);
    bad_txd = 0; bad_done = 0; bad_busy = 0;
    for (int c = 0; c < total; c++) begin
      if (c > 0) @(negedge clk);
      if (txd !== bits[c / (div + 1)]) bad_txd++;
      if (tx_done !== (c == total - 1)) bad_done++;
      if (busy !== 1'b1) bad_busy++;
    end
    check({tag, "_txd"}, bad_txd, 0);
    check({tag, "_tx_done"}, bad_done, 0);
    check({tag, "_busy"}, bad_busy, 0);
  endtask

  initial begin
    int bad;
    rst = 1'b1; tx_en = 1'b0; baud_div = 16'd3; stop2 = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_en = 1'b0; parity_odd = 1'b0;
`endif
    repeat (3) @(negedge clk);
    check("reset_txd", txd, 1'b1);
    check("reset_busy", busy, 1'b0);
    check("reset_rinc", fifo_rinc, 1'b0);
    check("reset_done", tx_done, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_busy", busy, 1'b0);

    // 1: single 0x55 frame, 4 clk/bit, 8N1
    push(8'h55);
    tx_en = 1'b1;
    wait_start("t1");
    check_frame("t1_55", 8'h55, 3, 1, -1);
    exp_pops += 1; exp_done += 1;
    @(negedge clk);
    check("t1_busy_after", busy, 1'b0);
    check("t1_pops", pops, exp_pops);

    // 2: back-to-back frames at 1 clk/bit
    baud_div = 16'd0;
    push(8'hA3); push(8'h0F);
    wait_start("t2a");
    check_frame("t2_A3", 8'hA3, 0, 1, -1);
    wait_start("t2b_gap");
    check_frame("t2_0F", 8'h0F, 0, 1, -1);
    exp_pops += 2; exp_done += 2;
    @(negedge clk);
    check("t2_busy_after", busy, 1'b0);
    check("t2_pops", pops, exp_pops);

    // 3: empty FIFO never popped; disabled TX never pops
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (fifo_rinc !== 1'b0 || txd !== 1'b1 || busy !== 1'b0) bad++;
    end
    check("t3_empty_idle", bad, 0);
    tx_en = 1'b0;
    push(8'hFF);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (fifo_rinc !== 1'b0 || busy !== 1'b0) bad++;
    end
    check("t3_disabled_idle", bad, 0);
    check("t3_pops", pops, exp_pops);

    // 4: reset in the third data bit of 0xFF, then a fresh frame
    baud_div = 16'd3;
    tx_en = 1'b1;
    wait_start("t4a");
    exp_pops += 1;
    repeat (13) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("t4_rst_txd", txd, 1'b1);
    check("t4_rst_busy", busy, 1'b0);
    check("t4_rst_rinc", fifo_rinc, 1'b0);
    check("t4_rst_done", done_cnt, exp_done);
    push(8'hFF);
    rst = 1'b0;
    wait_start("t4b");
    check_frame("t4_FF", 8'hFF, 3, 1, -1);
    exp_pops += 1; exp_done += 1;
    check("t4_pops", pops, exp_pops);

    // 5: divisor/stop2 change mid-frame only affects the next frame
    @(negedge clk);
    push(8'h3C); push(8'h81);
    wait_start("t5a");
    baud_div = 16'd7;
    stop2 = 1'b1;
    check_frame("t5_3C", 8'h3C, 3, 1, -1);
    wait_start("t5b_gap");
    check_frame("t5_81", 8'h81, 7, 2, -1);
    exp_pops += 2; exp_done += 2;
    tx_en = 1'b0;
    @(negedge clk);
    check("t5_busy_after", busy, 1'b0);

`ifdef UART_TX_PARITY_EN
    // 6: parity bit after the data, even then odd
    baud_div = 16'd1; stop2 = 1'b0;
    parity_en = 1'b1; parity_odd = 1'b0;
    push(8'h07);
    tx_en = 1'b1;
    wait_start("t6a");
    check_frame("t6_even", 8'h07, 1, 1, 1);
    @(negedge clk);
    parity_odd = 1'b1;
    push(8'h07);
    wait_start("t6b");
    check_frame("t6_odd", 8'h07, 1, 1, 0);
    exp_pops += 2; exp_done += 2;
    tx_en = 1'b0;
    @(negedge clk);
`endif

    repeat (2) @(negedge clk);
    check("final_pops", pops, exp_pops);
    check("final_done", done_cnt, exp_done);
    check("final_bad_pops", bad_pops, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
